// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: game phase sequencer, move strobe generator, heading arbiter and score/level keeper
//   in : clk, rst (async active-low), btn_up/down/left/right/start/pause (1-cycle pulses), game_state[1:0]
//   out: body_rst, body_start, move_clk, dir[1:0], score[7:0], level[3:0], phase[1:0] (all registered)
module snake_game_ctrl #(
  parameter int BASE_TICKS       = 25000000,
  parameter int STEP_TICKS       = 2000000,
  parameter int MIN_TICKS        = 5000000,
  parameter int APPLES_PER_LEVEL = 5,
  parameter int MAX_LEVEL        = 9,
  parameter int CNT_W            = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic [1:0] game_state,
  output logic       body_rst,
  output logic       body_start,
  output logic       move_clk,
  output logic [1:0] dir,
  output logic [7:0] score,
  output logic [3:0] level,
  output logic [1:0] phase
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DEAD = 2'b11} phase_t;
  phase_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [1:0] pending, gs_prev, cand;
  logic [7:0] acnt;
  logic [31:0] dec, period;
  logic dead, start_go, running, tick, accept, apple, lvl_up;
  assign phase = state;
  always_comb begin
    dead     = game_state == 2'b10;
    start_go = (state == IDLE || state == DEAD) && btn_start;
    // death beats pause; the counter only advances in a RUN cycle that stays in RUN
    state_nx = start_go ? RUN :
               state == RUN ? (dead ? DEAD : btn_pause ? PAUSE : RUN) :
               (state == PAUSE && btn_pause) ? RUN : state;
    running  = state == RUN && !dead && !btn_pause;
    dec      = 32'(level) * 32'(STEP_TICKS);
    period   = (32'(BASE_TICKS) >= 32'(MIN_TICKS) + dec) ? 32'(BASE_TICKS) - dec : 32'(MIN_TICKS);
    // >= lets a mid-count level-up shorten the current move instead of wrapping
    tick     = running && 32'(cnt) >= period - 32'd1;
    cand     = btn_up ? 2'b11 : btn_down ? 2'b10 : btn_left ? 2'b01 : 2'b00;
    // reversal is judged against the committed heading, not the pending one
    accept   = state == RUN && (btn_up || btn_down || btn_left || btn_right) &&
               !(cand[1] == dir[1] && cand[0] != dir[0]);
    apple    = gs_prev != 2'b01 && game_state == 2'b01;
    lvl_up   = acnt + 8'd1 >= 8'(APPLES_PER_LEVEL);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      body_rst   <= 1'b1;
      body_start <= 1'b0;
      move_clk   <= 1'b0;
      dir        <= 2'b00;
      pending    <= 2'b00;
      score      <= 8'd0;
      level      <= 4'd0;
      acnt       <= 8'd0;
      cnt        <= '0;
      gs_prev    <= 2'b00;
    end else begin
      state      <= state_nx;
      body_rst   <= state_nx == IDLE || state_nx == DEAD;
      body_start <= state_nx == RUN;
      move_clk   <= tick;
      gs_prev    <= game_state;
      if (start_go) begin
        cnt     <= '0;
        dir     <= 2'b00;
        pending <= 2'b00;
        score   <= 8'd0;
        level   <= 4'd0;
        acnt    <= 8'd0;
      end else begin
        if (running) cnt <= tick ? '0 : cnt + CNT_W'(1);
        if (tick) dir <= pending;
        if (accept) pending <= cand;
        if (apple) begin
          score <= score == 8'hff ? score : score + 8'd1;
          acnt  <= lvl_up ? 8'd0 : acnt + 8'd1;
          if (lvl_up && level < 4'(MAX_LEVEL)) level <= level + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed self-checking bench for snake_game_ctrl
module tb_snake_game_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_start = 0, btn_pause = 0;
  logic [1:0] game_state = 2'b00;
  logic body_rst, body_start, move_clk;
  logic [1:0] dir, phase;
  logic [7:0] score;
  logic [3:0] level;
  int passed = 0, total = 0;

  snake_game_ctrl #(.BASE_TICKS(20), .STEP_TICKS(4), .MIN_TICKS(8), .APPLES_PER_LEVEL(2),
                    .MAX_LEVEL(3), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_start(btn_start), .btn_pause(btn_pause), .game_state(game_state),
    .body_rst(body_rst), .body_start(body_start), .move_clk(move_clk), .dir(dir),
    .score(score), .level(level), .phase(phase));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_move(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (move_clk !== 1'b1 && n < 200);
  endtask

  task automatic test_reset();
    repeat (3) step();
    total++; if ({phase, body_rst, body_start, move_clk} !== 5'b00100) $display("FAIL reset_ctrl got %b want 00100", {phase, body_rst, body_start, move_clk}); else passed++;
    total++; if ({dir, score, level} !== 14'd0) $display("FAIL reset_data got dir=%b score=%0d level=%0d want 0", dir, score, level); else passed++;
    rst = 1'b1;
    repeat (5) step();
    total++; if (phase !== 2'b00 || move_clk !== 1'b0) $display("FAIL idle_hold got phase=%b move_clk=%b want 00/0", phase, move_clk); else passed++;
  endtask

  task automatic test_start();
    int n;
    btn_start = 1; step(); btn_start = 0;
    total++; if ({phase, body_rst, body_start} !== 4'b0101) $display("FAIL start got %b want 0101", {phase, body_rst, body_start}); else passed++;
    wait_move(n);
    total++; if (n !== 20) $display("FAIL first_move got %0d want 20", n); else passed++;
    wait_move(n);
    total++; if (n !== 20 || dir !== 2'b00) $display("FAIL period0 got n=%0d dir=%b want 20/00", n, dir); else passed++;
    repeat (5) step();
    btn_start = 1; step(); btn_start = 0;
    wait_move(n);
    total++; if (n !== 14 || phase !== 2'b01) $display("FAIL start_in_run got n=%0d phase=%b want 14/01", n, phase); else passed++;
  endtask

  task automatic test_direction();
    int n;
    btn_left = 1; step(); btn_left = 0;
    wait_move(n);
    total++; if (dir !== 2'b00) $display("FAIL reverse_reject got %b want 00", dir); else passed++;
    btn_up = 1; step(); btn_up = 0;
    btn_left = 1; step(); btn_left = 0;
    wait_move(n);
    total++; if (dir !== 2'b11) $display("FAIL up_then_left got %b want 11", dir); else passed++;
    btn_left = 1; btn_right = 1; step(); btn_left = 0; btn_right = 0;
    wait_move(n);
    total++; if (dir !== 2'b01) $display("FAIL left_over_right got %b want 01", dir); else passed++;
    btn_up = 1; btn_left = 1; step(); btn_up = 0; btn_left = 0;
    wait_move(n);
    total++; if (dir !== 2'b11) $display("FAIL up_over_left got %b want 11", dir); else passed++;
    btn_down = 1; btn_right = 1; step(); btn_down = 0; btn_right = 0;
    wait_move(n);
    total++; if (dir !== 2'b11) $display("FAIL down_reject_no_fallthrough got %b want 11", dir); else passed++;
    repeat (19) step();
    btn_left = 1; step(); btn_left = 0;
    total++; if (move_clk !== 1'b1 || dir !== 2'b11) $display("FAIL press_on_tick got mc=%b dir=%b want 1/11", move_clk, dir); else passed++;
    wait_move(n);
    total++; if (n !== 20 || dir !== 2'b01) $display("FAIL press_on_tick_next got n=%0d dir=%b want 20/01", n, dir); else passed++;
  endtask

  task automatic test_score_level();
    int n;
    for (int i = 0; i < 4; i++) begin
      game_state = 2'b01; repeat (30) step();
      game_state = 2'b00; repeat (3) step();
    end
    total++; if (score !== 8'd4 || level !== 4'd2) $display("FAIL four_apples got score=%0d level=%0d want 4/2", score, level); else passed++;
    wait_move(n); wait_move(n);
    total++; if (n !== 12) $display("FAIL period_l2 got %0d want 12", n); else passed++;
    for (int i = 0; i < 2; i++) begin
      game_state = 2'b01; repeat (30) step();
      game_state = 2'b00; repeat (3) step();
    end
    total++; if (score !== 8'd6 || level !== 4'd3) $display("FAIL six_apples got score=%0d level=%0d want 6/3", score, level); else passed++;
    wait_move(n); wait_move(n);
    total++; if (n !== 8) $display("FAIL period_l3 got %0d want 8", n); else passed++;
    for (int i = 0; i < 250; i++) begin
      game_state = 2'b01; step();
      game_state = 2'b00; step();
    end
    total++; if (score !== 8'd255 || level !== 4'd3) $display("FAIL saturate got score=%0d level=%0d want 255/3", score, level); else passed++;
  endtask

  task automatic test_death_restart();
    game_state = 2'b10; btn_pause = 1; step(); btn_pause = 0;
    total++; if ({phase, body_rst, body_start, move_clk} !== 5'b11100 || score !== 8'd255) $display("FAIL death got %b score=%0d want 11100/255", {phase, body_rst, body_start, move_clk}, score); else passed++;
    game_state = 2'b00; repeat (3) step();
    btn_start = 1; step(); btn_start = 0;
    total++; if (phase !== 2'b01 || score !== 8'd0 || level !== 4'd0 || dir !== 2'b00) $display("FAIL restart got phase=%b score=%0d level=%0d dir=%b want 01/0/0/00", phase, score, level, dir); else passed++;
  endtask

  task automatic test_pause();
    int n, m;
    repeat (7) step();
    btn_pause = 1; step(); btn_pause = 0;
    total++; if (phase !== 2'b10 || body_start !== 1'b0) $display("FAIL pause got phase=%b bs=%b want 10/0", phase, body_start); else passed++;
    m = 0;
    btn_up = 1; step(); btn_up = 0;
    btn_start = 1; step(); btn_start = 0;
    for (int i = 0; i < 98; i++) begin
      step();
      if (move_clk === 1'b1) m++;
    end
    total++; if (m !== 0 || body_start !== 1'b0 || phase !== 2'b10) $display("FAIL paused got moves=%0d bs=%b phase=%b want 0/0/10", m, body_start, phase); else passed++;
    btn_pause = 1; step(); btn_pause = 0;
    wait_move(n);
    total++; if (n !== 13 || dir !== 2'b00) $display("FAIL resume got n=%0d dir=%b want 13/00", n, dir); else passed++;
  endtask

  task automatic test_async_reset();
    int n, m;
    btn_down = 1; step(); btn_down = 0;
    wait_move(n);
    game_state = 2'b01; step(); game_state = 2'b00; step();
    repeat (8) step();
    total++; if (dir !== 2'b10 || score !== 8'd1) $display("FAIL pre_reset got dir=%b score=%0d want 10/1", dir, score); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if ({phase, body_rst, body_start, move_clk} !== 5'b00100 || {dir, score, level} !== 14'd0) $display("FAIL async_reset got %b dir=%b score=%0d level=%0d", {phase, body_rst, body_start, move_clk}, dir, score, level); else passed++;
    step();
    rst = 1'b1;
    m = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (move_clk === 1'b1) m++;
    end
    total++; if (m !== 0 || phase !== 2'b00) $display("FAIL post_reset got moves=%0d phase=%b want 0/00", m, phase); else passed++;
  endtask

  initial begin
    test_reset();
    test_start();
    test_direction();
    test_score_level();
    test_death_restart();
    test_pause();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
- Top-level sequencer for the snake datapath (game body).
- Owns the game phase: idle, run, pause and dead. Generates the body's reset, start and move_clk strobes, and arbitrates the four direction buttons into one committed heading with anti-reversal.
- Counts apples eaten into a score and raises speed level as apples accumulate.
- Sits between the debounced button block and the game body; score and level feed the display.

Parameters:
- BASE_TICKS, 25000000: clk cycles per move at level 0.
- STEP_TICKS, 2000000: cycles removed from the move period per level.
- MIN_TICKS, 5000000: floor on the move period.
- APPLES_PER_LEVEL, 5: apples per level increment.
- MAX_LEVEL, 9: level saturation value.
- CNT_W, 26: move-counter width; must hold BASE_TICKS-1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-low reset.
- btn_up, input, 1: one-cycle pulse, already synchronized.
- btn_down, input, 1: pulse.
- btn_left, input, 1: pulse.
- btn_right, input, 1: pulse.
- btn_start, input, 1: pulse; start/restart.
- btn_pause, input, 1: pulse; toggles pause.
- game_state, input, 2: from body; 00 normal, 01 ate apple, 10 dead.
- body_rst, output, 1: active-high reset to body.
- body_start, output, 1: level enable to body.
- move_clk, output, 1: one-cycle move strobe to body.
- dir, output, 2: committed heading; 00 right, 01 left, 10 down, 11 up.
- score, output, 8: apples eaten, saturates at 255.
- level, output, 4: current speed level.
- phase, output, 2: 00 IDLE, 01 RUN, 10 PAUSE, 11 DEAD.

Behaviour:
- Reset values: phase=IDLE, body_rst=1, body_start=0, move_clk=0, dir=00, pending=00, score=0, level=0, apple counter=0, move counter=0, gs_prev=00. All outputs are registered.
- Assertion of rst in any phase, including mid-move, forces the reset values immediately.
- IDLE and DEAD:
  - body_rst=1, body_start=0, no move_clk.
  - btn_start goes to RUN next cycle. On that transition: score, level, apple counter and move counter clear; dir and pending become 00 (right).
- RUN:
  - body_rst=0, body_start=1.
  - Move counter increments each cycle.
  - When counter >= period-1: move_clk=1 for exactly one cycle, counter returns to 0, and dir<=pending in the same cycle.
  - period = max(MIN_TICKS, BASE_TICKS - level*STEP_TICKS). The >= compare makes a level-up mid-count take effect without wrap.
  - btn_pause goes to PAUSE.
  - game_state==10 goes to DEAD next cycle, with no move_clk in that cycle.
  - btn_start in RUN is ignored.
- PAUSE:
  - body_start=0; counter frozen; move_clk=0.
  - Direction buttons are ignored.
  - btn_pause returns to RUN with the counter resumed from its frozen value.
  - btn_start is ignored.
- Direction arbitration (RUN only):
  - Priority when several buttons pulse in one cycle: up > down > left > right.
  - The candidate is rejected if it is the reverse of the committed dir, i.e. same bit1 and different bit0. The reversal check is against dir, not pending.
  - An accepted candidate overwrites pending; the last accepted press before a move_clk wins. At most one heading change per move.
  - Button pulse in the same cycle as move_clk: dir takes the old pending value; the new press lands in pending for the next move.
- Score and level:
  - gs_prev registers game_state every cycle.
  - On gs_prev!=01 && game_state==01: score+1, saturating at 255; apple counter+1.
  - When the apple counter reaches APPLES_PER_LEVEL: it clears to 0 and level+1, saturating at MAX_LEVEL.
  - A 01 held across many cycles counts once.
- Simultaneous events: a death (10) always wins over a pause press in the same cycle, so the phase goes to DEAD.

Test Plan (sim params BASE_TICKS=20, STEP_TICKS=4, MIN_TICKS=8, APPLES_PER_LEVEL=2, MAX_LEVEL=3):
- Reset then btn_start -> phase=01, body_rst=0, body_start=1; move_clk pulses every 20 cycles; dir=00.
- In RUN with dir=00, pulse btn_left -> dir stays 00 at next move. Pulse btn_up, then btn_left before the tick -> dir=11 at the tick. Pulse up+left in one cycle -> pending=11.
- Drive game_state 00->01 held 30 cycles, four times (returning to 00 between) -> score=4, level=2, move period 12. Six such events -> level=3, period = max(8,8) = 8 cycles.
- Pause at counter=7 -> no move_clk for 100 cycles, body_start=0. Resume -> next move_clk 13 cycles later at level 0.
- game_state=10 together with btn_pause -> phase=11, body_rst=1, score held. btn_start -> score=0, level=0, phase=01.
- Assert rst mid-RUN at counter=10 -> all outputs at reset values within the same cycle. No move_clk until start.
